// File: rtl/execute_unit_pkg.sv
// execute_unit_pkg -- shared definitions for the EX stage.
//   ALU op codes (5-bit), multiplier FSM states, bus widths and an
//   unsigned-magnitude helper used when a signed multiply is issued.
package execute_unit_pkg;

  localparam int DATA_BUS        = 32;
  localparam int DOUBLE_DATA_BUS = 64;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUBU  = 5'd2,
    OP_SLT   = 5'd3,
    OP_SLTU  = 5'd4,
    OP_AND   = 5'd5,
    OP_OR    = 5'd6,
    OP_XOR   = 5'd7,
    OP_NOR   = 5'd8,
    OP_SLL   = 5'd9,
    OP_SRL   = 5'd10,
    OP_SRA   = 5'd11,
    OP_MFHI  = 5'd12,
    OP_MFLO  = 5'd13,
    OP_MTHI  = 5'd14,
    OP_MTLO  = 5'd15,
    OP_MULT  = 5'd16,
    OP_MULTU = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [DATA_BUS-1:0] abs32(input logic [DATA_BUS-1:0] v);
    return v[DATA_BUS-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/execute_unit_mult_iter.sv
// execute_unit_mult_iter -- iterative shift-add multiplier, one multiplier
// bit per BUSY cycle, with IDLE/BUSY/DONE control.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         abandon any in-flight multiply (no result written)
//   start_i         valid MULT/MULTU presented by ID/EX
//   signed_i        1 = MULT, 0 = MULTU
//   a_i, b_i        operands (a = multiplicand, b = multiplier)
//   busy_o          upstream must stall this cycle
//   done_o          in DONE state (multiply retires this cycle)
//   wr_o            product_o is final; write HI/LO at this edge
//   product_o       signed-corrected 64-bit product
// Build option: MULT_EARLY_TERM_EN leaves BUSY once the remaining
// multiplier bits are all zero (min. one BUSY cycle).
module execute_unit_mult_iter
  import execute_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       start_i,
  input  logic                       signed_i,
  input  logic [DATA_BUS-1:0]        a_i,
  input  logic [DATA_BUS-1:0]        b_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       wr_o,
  output logic [DOUBLE_DATA_BUS-1:0] product_o
);

  localparam int CNT_W = $clog2(MULT_CYCLES);

  mult_state_e                state_q, state_d;
  logic [DOUBLE_DATA_BUS-1:0] mcand_q, acc_q, acc_sum;
  logic [DATA_BUS-1:0]        mplier_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       sign_q;
  logic                       last;

  // Accumulator value after this cycle's partial product.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MULT_EARLY_TERM_EN
  assign last = (cnt_q == CNT_W'(MULT_CYCLES-1)) || (mplier_q[DATA_BUS-1:1] == '0);
`else
  assign last = (cnt_q == CNT_W'(MULT_CYCLES-1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_BUSY;
      ST_BUSY: if (last)    state_d = ST_DONE;
      ST_DONE:              state_d = ST_IDLE;  // mult still in ID/EX must not reissue
      default:              state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Datapath; a flush only needs the state to return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (start_i && !flush_i) begin
        mcand_q  <= {{DATA_BUS{1'b0}}, signed_i ? abs32(a_i) : a_i};
        mplier_q <= signed_i ? abs32(b_i) : b_i;
        sign_q   <= signed_i & (a_i[DATA_BUS-1] ^ b_i[DATA_BUS-1]);
        acc_q    <= '0;
        cnt_q    <= '0;
      end
    end else if (state_q == ST_BUSY) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    busy_o    = !rst && !flush_i &&
                ((state_q == ST_IDLE && start_i) || state_q == ST_BUSY);
    done_o    = !rst && (state_q == ST_DONE);
    wr_o      = !rst && !flush_i && (state_q == ST_BUSY) && last;
    product_o = sign_q ? (~acc_sum + 1'b1) : acc_sum;
  end

endmodule

// File: rtl/execute_unit.sv
// execute_unit -- EX-stage datapath: combinational ALU, HI/LO registers and
// an iterative multiplier that stalls upstream while a MULT/MULTU runs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               cancel EX instruction and any in-flight multiply
//   valid_in            ID/EX holds a valid instruction
//   alu_op              op code (execute_unit_pkg::alu_op_e)
//   operand_1/2         ID/EX operands
//   result              combinational EX result
//   result_valid        result is final this cycle
//   hi, lo              architectural HI/LO
//   stall_req           hold PC, IF/ID and ID/EX this cycle
// Build option: MULT_EARLY_TERM_EN (see execute_unit_mult_iter).
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [4:0]          alu_op,
  input  logic [DATA_BUS-1:0] operand_1,
  input  logic [DATA_BUS-1:0] operand_2,
  output logic [DATA_BUS-1:0] result,
  output logic                result_valid,
  output logic [DATA_BUS-1:0] hi,
  output logic [DATA_BUS-1:0] lo,
  output logic                stall_req
);

  logic [DATA_BUS-1:0]        hi_q, lo_q;
  logic                       is_mult, mul_busy, mul_done, mul_wr;
  logic [DOUBLE_DATA_BUS-1:0] mul_prod;

  assign is_mult = (alu_op == OP_MULT) || (alu_op == OP_MULTU);

  execute_unit_mult_iter #(.MULT_CYCLES(MULT_CYCLES)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .start_i   (valid_in && is_mult),
    .signed_i  (alu_op == OP_MULT),
    .a_i       (operand_1),
    .b_i       (operand_2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .wr_o      (mul_wr),
    .product_o (mul_prod)
  );

  assign stall_req    = mul_busy;
  // Single-cycle ops retire immediately; a multiply retires in DONE,
  // which is the first cycle it is presented without a stall.
  assign result_valid = !rst && valid_in && !flush && !mul_busy;

  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADDU: result = operand_1 + operand_2;
      OP_SUBU: result = operand_1 - operand_2;
      OP_SLT:  result = {31'd0, $signed(operand_1) < $signed(operand_2)};
      OP_SLTU: result = {31'd0, operand_1 < operand_2};
      OP_AND:  result = operand_1 & operand_2;
      OP_OR:   result = operand_1 | operand_2;
      OP_XOR:  result = operand_1 ^ operand_2;
      OP_NOR:  result = ~(operand_1 | operand_2);
      OP_SLL:  result = operand_2 << operand_1[4:0];
      OP_SRL:  result = operand_2 >> operand_1[4:0];
      OP_SRA:  result = $signed(operand_2) >>> operand_1[4:0];
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = '0;  // MTHI/MTLO, MULT/MULTU, NOP, unknown
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mul_wr) begin
      {hi_q, lo_q} <= mul_prod;
    end else if (result_valid && !mul_done) begin
      if (alu_op == OP_MTHI) hi_q <= operand_1;
      if (alu_op == OP_MTLO) lo_q <= operand_1;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;
  import execute_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in;
  logic [4:0]  alu_op;
  logic [31:0] op1, op2;
  logic [31:0] result, hi, lo;
  logic        result_valid, stall_req;

  execute_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .alu_op(alu_op),
    .operand_1(op1), .operand_2(op2), .result(result), .result_valid(result_valid),
    .hi(hi), .lo(lo), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  alu_op_e sops [15] = '{OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR,
                         OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference ALU from the instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADDU: return a + b;
      OP_SUBU: return a - b;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return 32'(longint'(b) * (longint'(1) << a[4:0]));
      OP_SRL:  return 32'(longint'(b) / (longint'(1) << a[4:0]));
      OP_SRA:  return 32'(sb >>> a[4:0]);
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; flush = 1'b0; alu_op = OP_NOP;
  endtask

  // One single-cycle op, optionally flushed.
  task automatic single(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl);
    valid_in = 1'b1; alu_op = op; op1 = a; op2 = b; flush = fl;
    @(negedge clk);
    chk("result", result, ref_alu(op, a, b));
    chk("rvalid", result_valid, !fl);
    chk("stall", stall_req, 1'b0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk); #1;
    if (!fl && op == OP_MTHI) m_hi = a;
    if (!fl && op == OP_MTLO) m_lo = a;
    idle();
  endtask

  // Hold a multiply valid until it retires; check latency and HI/LO.
  task automatic do_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] mb;
    int nb, cyc;
    if (sgn) prod = 64'(longint'($signed(a)) * longint'($signed(b)));
    else     prod = {32'd0, a} * {32'd0, b};
    mb = (sgn && b[31]) ? 32'(-longint'($signed(b))) : b;
`ifdef MULT_EARLY_TERM_EN
    nb = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) nb = i + 1;
`else
    nb = 32;
`endif
    valid_in = 1'b1; alu_op = sgn ? OP_MULT : OP_MULTU; op1 = a; op2 = b; flush = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (stall_req && cyc < 200) begin
      if (result_valid) chk("rvalid_stalled", result_valid, 1'b0);
      cyc++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", 64'(cyc), 64'(nb + 1));
    chk("mul_done_rvalid", result_valid, 1'b1);
    chk("mul_done_result", result, 32'd0);
    chk("mul_hi", hi, prod[63:32]);
    chk("mul_lo", lo, prod[31:0]);
    m_hi = prod[63:32]; m_lo = prod[31:0];
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("mul_after_stall", stall_req, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    idle(); op1 = '0; op2 = '0;
    rst = 1'b1;
    valid_in = 1'b1; alu_op = OP_MULTU; op1 = 32'd3; op2 = 32'd5;
    @(negedge clk);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_rvalid", result_valid, 1'b0);
    step(); step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0; idle(); step();

    // Directed ALU cases
    single(OP_ADDU, 32'hFFFFFFFF, 32'h2, 1'b0);
    single(OP_SLT,  32'hFFFFFFFF, 32'h1, 1'b0);
    single(OP_SLTU, 32'hFFFFFFFF, 32'h1, 1'b0);
    single(OP_SRA,  32'd4, 32'h80000000, 1'b0);
    valid_in = 1'b1; alu_op = OP_SRA; op1 = 32'd4; op2 = 32'h80000000;
    @(negedge clk);
    chk("sra_const", result, 32'hF8000000);
    step(); idle();
    single(5'd31, 32'h1234, 32'h5678, 1'b0);  // unknown op -> 0

    // Multiplies
    do_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulu_hi_const", hi, 32'hFFFFFFFE);
    single(OP_MFHI, 32'd0, 32'd0, 1'b0);
    do_mult(1'b1, 32'hFFFFFFFD, 32'd7);
    chk("mult_neg_lo_const", lo, 32'hFFFFFFEB);
    do_mult(1'b1, 32'h80000000, 32'h80000000);
    chk("mult_min_hi_const", hi, 32'h40000000);

    // Flush at BUSY cycle 10
    single(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
    valid_in = 1'b1; alu_op = OP_MULT; op1 = 32'd9; op2 = 32'h80000001;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", stall_req, 1'b0);
    chk("flush_rvalid", result_valid, 1'b0);
    step(); idle();
    @(negedge clk);
    chk("flush_idle_stall", stall_req, 1'b0);
    chk("flush_hi", hi, 32'h12345678);
    step();

    // Reset mid-BUSY
    valid_in = 1'b1; alu_op = OP_MULTU; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstb_stall", stall_req, 1'b0);
    step(); rst = 1'b0; idle();
    @(negedge clk);
    chk("rstb_idle_stall", stall_req, 1'b0);
    chk("rstb_hi", hi, 32'd0);
    chk("rstb_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    step();
    do_mult(1'b0, 32'd3, 32'd5);
    do_mult(1'b0, 32'h1234, 32'd1);
    do_mult(1'b1, 32'h7, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0)
        do_mult($urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 300));
      else
        single(sops[$urandom_range(0, 14)], $urandom, $urandom, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
EX-stage datapath. Consumes operand_1/operand_2 from the ID/EX register, which is fed by ID operand generation, and produces the ALU result for EX/MEM. Holds the architectural HI/LO registers. Runs MULT/MULTU on an iterative shift-add multiplier and raises stall_req to freeze upstream stages while the multiply is in flight.

Parameters:
MULT_CYCLES, 32, number of BUSY iterations per multiply (one multiplier bit per cycle); must equal data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  cancels the EX instruction and any in-flight multiply.
- valid_in  in  1  ID/EX holds a valid instruction.
- alu_op  in  5  operation code from the shared ALU-op package.
- operand_1  in  32  first operand from ID/EX.
- operand_2  in  32  second operand from ID/EX.
- result  out  32  EX result; combinational.
- result_valid  out  1  result is final this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stall_req  out  1  hold PC, IF/ID and ID/EX this cycle.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high. On rst: state=IDLE, hi=0, lo=0, counter=0, internal accumulators=0. While rst is high, stall_req=0 and result_valid=0.
- Single-cycle ops (zero latency, combinational):
  - ADDU: op1+op2, mod 2^32.
  - SUBU: op1-op2.
  - SLT: signed op1<op2, yields 1 or 0.
  - SLTU: unsigned op1<op2, yields 1 or 0.
  - AND, OR, XOR, NOR: bitwise.
  - SLL, SRL, SRA: op2 shifted by op1[4:0].
  - MFHI: result=hi. MFLO: result=lo.
  - MTHI: hi<=op1 at clock edge. MTLO: lo<=op1 at clock edge. Result for MTHI/MTLO is 0.
  - NOP/unknown alu_op: result=0.
  - result_valid=valid_in & ~flush.
- MULT/MULTU FSM, states IDLE, BUSY, DONE:
  - IDLE + valid_in + mult op + ~flush: latch |op1| and |op2| (raw values for MULTU) and sign=op1[31]^op2[31] (MULT only). Clear the 64-bit accumulator, counter=0, go to BUSY. stall_req=1 combinationally in this issue cycle.
  - BUSY: each cycle, if multiplier bit0=1 add the shifted multiplicand to the accumulator; shift multiplicand left and multiplier right; counter++. stall_req=1. After counter reaches MULT_CYCLES-1, go to DONE and write {hi,lo} <= sign ? -acc : acc (64-bit two's complement).
  - DONE: stall_req=0, result_valid=1 (result=0). ID/EX still presents the same mult, which must not restart. Next state is IDLE.
  - Latency: issue cycle + 32 BUSY cycles stalled; retires in the 34th cycle (DONE).
- flush in any state: next state=IDLE, hi/lo unchanged, no partial write; stall_req=0 in the flush cycle.
- MTHI/MTLO cannot coincide with a multiply, because upstream is stalled.
- MULT of 0x80000000 by 0x80000000: the magnitudes use unsigned 32-bit abs (0x80000000). Product is 0x4000000000000000.
- valid_in=0 in IDLE: no state change; stall_req=0.

Optional Feature:
MULT_EARLY_TERM_EN:
- Defined: BUSY exits to DONE in the cycle after the remaining multiplier becomes zero, with a minimum of 1 BUSY cycle. Multiply by 0 or 1 takes 1 BUSY cycle.
- Undefined: fixed MULT_CYCLES BUSY cycles. Results are identical either way; only latency differs.

Decomposition:
- Shared package/include alu_op.v:
  - ALU op codes: ADDU, SUBU, SLT, SLTU, AND, OR, XOR, NOR, SLL, SRL, SRA, MFHI, MFLO, MTHI, MTLO, MULT, MULTU, NOP.
  - FSM state encodings.
- bus.v: DATA_BUS and DOUBLE_DATA_BUS widths.
- Sub-module mult_iter: owns the FSM, counter, accumulator and sign fix-up. It has outputs busy, done and product[63:0]. execute_unit owns the ALU mux and the HI/LO registers.

Test Plan:
1. ADDU 0xFFFFFFFF+0x00000002 -> result 0x00000001, result_valid=1, stall_req=0. SLT 0xFFFFFFFF,0x1 -> 1; SLTU same operands -> 0. SRA op1=4, op2=0x80000000 -> 0xF8000000.
2. MULTU 0xFFFFFFFF×0xFFFFFFFF held valid -> stall_req=1 for 33 cycles, DONE in cycle 34 -> hi=0xFFFFFFFE, lo=0x00000001. Then MFHI -> 0xFFFFFFFE.
3. MULT 0xFFFFFFFD(-3)×7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
4. MTHI 0x12345678 then MULT started; flush asserted at BUSY cycle 10 -> state IDLE next cycle, stall_req=0, hi still 0x12345678.
5. rst asserted mid-BUSY -> next cycle IDLE, hi=lo=0, stall_req=0. A new MULTU 3×5 then gives lo=15, hi=0.
6. With MULT_EARLY_TERM_EN, MULTU 0x1234×1 -> 1 BUSY cycle, lo=0x1234. Without the macro, the same stimulus takes 32 BUSY cycles and gives the same lo.
